// File: rtl/wb_slave_pkg.sv
// Shared definitions for the Wishbone SRAM slave.
//   wb_slave_state_e : handshake FSM state encoding
//   WB_WAIT_MAX      : largest supported wait-state count
//   sel_is_legal     : byte-lane pattern check (single byte, aligned half, full word)
package wb_slave_pkg;

    localparam int unsigned WB_WAIT_MAX = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } wb_slave_state_e;

    // Only naturally aligned byte, half-word and word lane patterns are accepted.
    function automatic logic sel_is_legal(input logic [3:0] sel);
        case (sel)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/wb_sram_bytelane_mem.sv
// DEPTH x 32 word memory with per-byte-lane write enables and a registered read port.
//   clk, reset_n : clock and async active-low reset (read register only; array not reset)
//   addr         : word index
//   be           : byte-lane write enables
//   wdata        : write data, lanes aligned to be
//   re           : load rdata from addr on the next rising edge
//   rdata        : last word read; holds between reads
module wb_sram_bytelane_mem #(
    parameter  int unsigned DEPTH = 128,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    be,
    input  logic [31:0]   wdata,
    input  logic          re,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= 32'h0;
        end else if (re) begin
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/wb_sram_slave.sv
// Wishbone B4 classic-cycle SRAM slave with programmable wait states.
//   clk, reset_n : clock and async active-low reset
//   wb_adr_i     : byte address; only [AW+1:2] used, upper bits alias
//   wb_dat_i     : write data, lanes aligned to wb_sel_i
//   wb_sel_i     : byte-lane enables; illegal patterns end in wb_err_o
//   wb_we_i      : 1 = write, 0 = read
//   wb_cyc_i     : bus cycle active
//   wb_stb_i     : strobe
//   wb_dat_o     : registered read data, holds last read value
//   wb_ack_o     : registered one-cycle normal termination
//   wb_err_o     : registered one-cycle error termination
module wb_sram_slave
    import wb_slave_pkg::*;
#(
    parameter int unsigned DEPTH       = 128,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(WB_WAIT_MAX + 1);
    localparam logic [CW-1:0] CNT_LOAD = (WAIT_STATES > 0) ? CW'(WAIT_STATES - 1) : '0;

    wb_slave_state_e state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   adr_q;
    logic [31:0]     dat_q;
    logic [3:0]      sel_q;
    logic            we_q;
    logic            legal_q;
    logic            ack_q, ack_d;
    logic            err_q, err_d;

    logic            req;
    logic            latch;
    logic            commit;
    logic [AW-1:0]   c_adr;
    logic [31:0]     c_dat;
    logic [3:0]      c_sel;
    logic            c_we;
    logic            c_legal;
    logic [3:0]      mem_be;
    logic            mem_re;
    logic            unused_adr;

    assign req        = wb_cyc_i & wb_stb_i;
    assign unused_adr = ^{wb_adr_i[31:AW+2], wb_adr_i[1:0]};

    // With zero wait states the commit edge is the sampling edge, so the live bus
    // fields are used instead of the not-yet-loaded latches.
    always_comb begin
        if (state_q == IDLE) begin
            c_adr   = wb_adr_i[AW+1:2];
            c_dat   = wb_dat_i;
            c_sel   = wb_sel_i;
            c_we    = wb_we_i;
            c_legal = sel_is_legal(wb_sel_i);
        end else begin
            c_adr   = adr_q;
            c_dat   = dat_q;
            c_sel   = sel_q;
            c_we    = we_q;
            c_legal = legal_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        latch   = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    latch = 1'b1;
                    cnt_d = CNT_LOAD;
                    if (WAIT_STATES == 0) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    // Master abandoned the cycle: no write, no termination.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign ack_d  = commit & c_legal;
    assign err_d  = commit & ~c_legal;
    assign mem_be = (commit & c_we & c_legal) ? c_sel : 4'b0000;
    assign mem_re = commit & ~c_we & c_legal;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            legal_q <= 1'b0;
        end else if (latch) begin
            adr_q   <= wb_adr_i[AW+1:2];
            dat_q   <= wb_dat_i;
            sel_q   <= wb_sel_i;
            we_q    <= wb_we_i;
            legal_q <= sel_is_legal(wb_sel_i);
        end
    end

    wb_sram_bytelane_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .reset_n (reset_n),
        .addr    (c_adr),
        .be      (mem_be),
        .wdata   (c_dat),
        .re      (mem_re),
        .rdata   (wb_dat_o)
    );

    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;

endmodule

// File: tb/tb_wb_sram_slave.sv
// Scoreboard bench for wb_sram_slave: three instances (WAIT_STATES 1, 3, 0), each driven
// in turn; a monitor pops expected terminations and compares kind, data and latency.
module tb_wb_sram_slave;

    localparam int N     = 3;
    localparam int DEPTH = 128;

    typedef struct {
        logic        err;
        logic [31:0] dat;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n [N];
    logic [31:0] adr     [N];
    logic [31:0] dati    [N];
    logic [31:0] dato    [N];
    logic [3:0]  sel     [N];
    logic        we      [N];
    logic        cyc     [N];
    logic        stb     [N];
    logic        ack     [N];
    logic        err     [N];

    int          errors  = 0;
    int          checks  = 0;
    int          cyc_cnt = 0;
    int          cur     = 0;

    exp_t        q [$];
    exp_t        mon_e;

    logic [31:0] model [N][DEPTH];
    logic [31:0] mdout [N];
    logic [3:0]  legal_list [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                    4'b0011, 4'b1100, 4'b1111};

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    for (genvar g = 0; g < N; g++) begin : g_dut
        wb_sram_slave #(
            .DEPTH       (DEPTH),
            .WAIT_STATES ((g == 0) ? 1 : ((g == 1) ? 3 : 0))
        ) u_dut (
            .clk      (clk),
            .reset_n  (reset_n[g]),
            .wb_adr_i (adr[g]),
            .wb_dat_i (dati[g]),
            .wb_sel_i (sel[g]),
            .wb_we_i  (we[g]),
            .wb_cyc_i (cyc[g]),
            .wb_stb_i (stb[g]),
            .wb_dat_o (dato[g]),
            .wb_ack_o (ack[g]),
            .wb_err_o (err[g])
        );
    end

    function automatic int wait_of(input int d);
        case (d)
            0:       return 1;
            1:       return 3;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every termination of the active instance must match the oldest expectation.
    always @(negedge clk) begin
        if (ack[cur] === 1'b1 || err[cur] === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_term: dut %0d ack=%b err=%b with nothing pending",
                         cur, ack[cur], err[cur]);
            end else begin
                mon_e = q.pop_front();
                check("ack", {31'b0, ack[cur]}, {31'b0, ~mon_e.err});
                check("err", {31'b0, err[cur]}, {31'b0, mon_e.err});
                check("dat_o", dato[cur], mon_e.dat);
                check("latency", cyc_cnt, mon_e.due);
            end
        end
    end

    // One complete bus transaction, called at a negedge with the slave idle.
    task automatic xfer(input int d, input logic w, input logic [31:0] a,
                        input logic [31:0] dv, input logic [3:0] s, input bit rst_in_resp);
        exp_t e;
        int   idx;
        bit   legal;
        bit   done;
        idx   = int'(a[8:2]);
        legal = s inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
        if (legal && w) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) model[d][idx][8*b +: 8] = dv[8*b +: 8];
            end
        end else if (legal) begin
            mdout[d] = model[d][idx];
        end
        e.err = ~legal;
        e.dat = mdout[d];
        e.due = cyc_cnt + wait_of(d) + 1;
        q.push_back(e);
        adr[d]  = a;
        dati[d] = dv;
        sel[d]  = s;
        we[d]   = w;
        cyc[d]  = 1'b1;
        stb[d]  = 1'b1;
        done    = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (ack[d] === 1'b1 || err[d] === 1'b1) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout: dut %0d addr %h no termination in 50 cycles", d, a);
            q.delete();
        end
        cyc[d] = 1'b0;
        stb[d] = 1'b0;
        if (rst_in_resp && done) begin
            #2 reset_n[d] = 1'b0;
            #1;
            check("rst_resp_ack", {31'b0, ack[d]}, 32'h0);
            check("rst_resp_err", {31'b0, err[d]}, 32'h0);
            check("rst_resp_dat", dato[d], 32'h0);
            mdout[d] = 32'h0;
        end
        @(negedge clk);
        reset_n[d] = 1'b1;
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rd;
        logic [3:0]  rs;
        for (int d = 0; d < N; d++) begin
            reset_n[d] = 1'b0;
            adr[d]     = '0;
            dati[d]    = '0;
            sel[d]     = '0;
            we[d]      = 1'b0;
            cyc[d]     = 1'b0;
            stb[d]     = 1'b0;
            mdout[d]   = 32'h0;
        end
        #12;
        for (int d = 0; d < N; d++) begin
            check("reset_ack", {31'b0, ack[d]}, 32'h0);
            check("reset_err", {31'b0, err[d]}, 32'h0);
            check("reset_dat", dato[d], 32'h0);
        end
        @(negedge clk);
        @(negedge clk);
        for (int d = 0; d < N; d++) reset_n[d] = 1'b1;
        @(negedge clk);

        // Instance 0, one wait state: fill memory, directed cases, then random traffic.
        cur = 0;
        for (int i = 0; i < DEPTH; i++) xfer(0, 1'b1, 32'(i * 4), $urandom(), 4'b1111, 1'b0);
        xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 1'b0);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'b1111, 1'b0);
        check("read_deadbeef", dato[0], 32'hDEADBEEF);
        xfer(0, 1'b1, 32'h10, 32'h00AA0000, 4'b0100, 1'b0);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'b1111, 1'b0);
        check("read_byte2", dato[0], 32'hDEAABEEF);
        xfer(0, 1'b1, 32'h10, 32'h12345678, 4'b0101, 1'b0);
        check("err_dat_hold", dato[0], 32'hDEAABEEF);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'b0000, 1'b0);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'b1111, 1'b0);
        check("err_no_write", dato[0], 32'hDEAABEEF);
        for (int i = 0; i < 200; i++) begin
            ra = $urandom();
            rd = $urandom();
            rs = ($urandom_range(3) == 0) ? 4'($urandom_range(15))
                                          : legal_list[$urandom_range(6)];
            xfer(0, 1'($urandom_range(1)), ra, rd, rs, 1'b0);
        end
        xfer(0, 1'b0, 32'h10, 32'h0, 4'b1111, 1'b1);
        xfer(0, 1'b0, 32'h14, 32'h0, 4'b0011, 1'b0);

        // Instance 1, three wait states: abort in WAIT, then reset in WAIT.
        cur = 1;
        xfer(1, 1'b1, 32'h20, 32'h12345678, 4'b1111, 1'b0);
        xfer(1, 1'b0, 32'h20, 32'h0, 4'b1111, 1'b0);
        adr[1] = 32'h20; dati[1] = 32'hCAFEF00D; sel[1] = 4'b1111; we[1] = 1'b1;
        cyc[1] = 1'b1; stb[1] = 1'b1;
        repeat (2) @(negedge clk);
        stb[1] = 1'b0;
        repeat (2) @(negedge clk);
        cyc[1] = 1'b0;
        repeat (6) @(negedge clk);
        xfer(1, 1'b0, 32'h20, 32'h0, 4'b1111, 1'b0);
        check("abort_no_write", dato[1], 32'h12345678);
        adr[1] = 32'h20; dati[1] = 32'h0BADF00D; sel[1] = 4'b1111; we[1] = 1'b1;
        cyc[1] = 1'b1; stb[1] = 1'b1;
        repeat (2) @(negedge clk);
        #2 reset_n[1] = 1'b0;
        #1;
        check("rst_wait_ack", {31'b0, ack[1]}, 32'h0);
        check("rst_wait_err", {31'b0, err[1]}, 32'h0);
        check("rst_wait_dat", dato[1], 32'h0);
        mdout[1] = 32'h0;
        cyc[1] = 1'b0; stb[1] = 1'b0;
        @(negedge clk);
        reset_n[1] = 1'b1;
        repeat (6) @(negedge clk);
        xfer(1, 1'b0, 32'h20, 32'h0, 4'b1111, 1'b0);
        check("rst_no_write", dato[1], 32'h12345678);

        // Instance 2, zero wait states: upper address bits alias onto the same word.
        cur = 2;
        xfer(2, 1'b1, 32'h000, 32'h11111111, 4'b1111, 1'b0);
        xfer(2, 1'b1, 32'h200, 32'h22222222, 4'b1111, 1'b0);
        xfer(2, 1'b0, 32'h000, 32'h0, 4'b1111, 1'b0);
        check("alias_read", dato[2], 32'h22222222);
        xfer(2, 1'b1, 32'h204, 32'h0000BEEF, 4'b0011, 1'b0);
        xfer(2, 1'b1, 32'h004, 32'hFFFF0000, 4'b1100, 1'b0);
        xfer(2, 1'b0, 32'h404, 32'h0, 4'b1111, 1'b0);
        xfer(2, 1'b1, 32'h004, 32'h0, 4'b1010, 1'b0);

        repeat (4) @(negedge clk);
        check("queue_empty", 32'(q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
